// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch time base: a prescaler divides clk down to 10 ms ticks, which drive a
// four-digit cascaded BCD counter (00.00-99.99). A run/pause/clear FSM gates the counting.
module stopwatch_bcd_counter #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] bcd3,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic       running,
  output logic       tick,
  output logic       wrap,
  output logic [1:0] state_dbg
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state_q;
  logic [PW-1:0] pre_q;
  logic [3:0]    bcd0_q, bcd1_q, bcd2_q, bcd3_q;
  logic [3:0]    bcd0_d, bcd1_d, bcd2_d, bcd3_d;
  logic          c0, c1, c2;
  logic          wrap_q;
  logic          all_nines;

  assign tick = (state_q == RUN) && (pre_q == PRE_LAST);

  // Whole carry chain resolves combinationally so one edge moves every digit at once.
  always_comb begin
    c0        = (bcd0_q == 4'd9);
    c1        = c0 && (bcd1_q == 4'd9);
    c2        = c1 && (bcd2_q == 4'd9);
    all_nines = c2 && (bcd3_q == 4'd9);
    bcd0_d    = c0 ? 4'd0 : bcd0_q + 4'd1;
    bcd1_d    = bcd1_q;
    bcd2_d    = bcd2_q;
    bcd3_d    = bcd3_q;
    if (c0) bcd1_d = (bcd1_q == 4'd9) ? 4'd0 : bcd1_q + 4'd1;
    if (c1) bcd2_d = (bcd2_q == 4'd9) ? 4'd0 : bcd2_q + 4'd1;
    if (c2) bcd3_d = (bcd3_q == 4'd9) ? 4'd0 : bcd3_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= IDLE;
      pre_q   <= '0;
      bcd0_q  <= 4'd0;
      bcd1_q  <= 4'd0;
      bcd2_q  <= 4'd0;
      bcd3_q  <= 4'd0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= tick && all_nines;
      if (tick) begin
        pre_q  <= '0;
        bcd0_q <= bcd0_d;
        bcd1_q <= bcd1_d;
        bcd2_q <= bcd2_d;
        bcd3_q <= bcd3_d;
      end else if (state_q == RUN) begin
        pre_q <= pre_q + 1'b1;
      end
      // Prescaler phase is kept in PAUSE so resume continues the partial tick.
      if (start_stop) begin
        case (state_q)
          IDLE:    state_q <= RUN;
          RUN:     state_q <= PAUSE;
          PAUSE:   state_q <= RUN;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bcd0      = bcd0_q;
  assign bcd1      = bcd1_q;
  assign bcd2      = bcd2_q;
  assign bcd3      = bcd3_q;
  assign wrap      = wrap_q;
  assign running   = (state_q == RUN);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Bench for stopwatch_bcd_counter: instance 0 uses a 10-cycle tick, instance 1 a
// 2-cycle tick so the full-scale rollover is reachable in a short run.
module tb_stopwatch_bcd_counter;

  logic       clk;
  logic       rst [2];
  logic       ss  [2];
  logic       clr [2];
  logic [3:0] d3 [2], d2 [2], d1 [2], d0 [2];
  logic       run_o [2], tick_o [2], wrap_o [2];
  logic [1:0] st_dbg [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: elapsed time as an integer count of hundredths.
  int m_time  [2];
  int m_phase [2];
  int m_mode  [2]; // 0 stopped/cleared, 1 counting, 2 paused
  bit m_wrap  [2];
  bit m_valid [2];
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(400000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  stopwatch_bcd_counter #(.CLK_HZ(1000), .TICK_HZ(100)) dut_a (
    .clk(clk), .reset(rst[0]), .start_stop(ss[0]), .clear(clr[0]),
    .bcd3(d3[0]), .bcd2(d2[0]), .bcd1(d1[0]), .bcd0(d0[0]),
    .running(run_o[0]), .tick(tick_o[0]), .wrap(wrap_o[0]), .state_dbg(st_dbg[0])
  );

  stopwatch_bcd_counter #(.CLK_HZ(200), .TICK_HZ(100)) dut_b (
    .clk(clk), .reset(rst[1]), .start_stop(ss[1]), .clear(clr[1]),
    .bcd3(d3[1]), .bcd2(d2[1]), .bcd1(d1[1]), .bcd0(d0[1]),
    .running(run_o[1]), .tick(tick_o[1]), .wrap(wrap_o[1]), .state_dbg(st_dbg[1])
  );

  function automatic int div_of(int i);
    return (i == 0) ? 10 : 2;
  endfunction

  function automatic logic [15:0] time_bcd(int t);
    return {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- model ----------------
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit t;
      t = (m_mode[i] == 1) && (m_phase[i] == div_of(i) - 1);
      if (rst[i] === 1'b1 || clr[i] === 1'b1) begin
        m_mode[i] = 0; m_phase[i] = 0; m_time[i] = 0; m_wrap[i] = 0;
        if (rst[i] === 1'b1) m_valid[i] = 1;
      end else begin
        m_wrap[i] = t && (m_time[i] == 9999);
        if (t) begin
          m_time[i]  = (m_time[i] + 1) % 10000;
          m_phase[i] = 0;
        end else if (m_mode[i] == 1) begin
          m_phase[i] = m_phase[i] + 1;
        end
        if (ss[i] === 1'b1) m_mode[i] = (m_mode[i] == 1) ? 2 : 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_valid[i]) begin
        chk("digits", {d3[i], d2[i], d1[i], d0[i]}, time_bcd(m_time[i]));
        chk("running", run_o[i], (m_mode[i] == 1));
        chk("tick", tick_o[i], (m_mode[i] == 1) && (m_phase[i] == div_of(i) - 1));
        chk("wrap", wrap_o[i], m_wrap[i]);
        chk("bcd_le9", (d3[i] > 9) || (d2[i] > 9) || (d1[i] > 9) || (d0[i] > 9), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ss(input int i);
    ss[i] = 1'b1; @(negedge clk); ss[i] = 1'b0;
  endtask

  task automatic pulse_clr(input int i);
    clr[i] = 1'b1; @(negedge clk); clr[i] = 1'b0;
  endtask

  task automatic pulse_rst(input int i);
    rst[i] = 1'b1; @(negedge clk); rst[i] = 1'b0;
  endtask

  // Hand-computed literal expectation checked against both DUT and model.
  task automatic expect_lit(input int i, input string name, input logic [15:0] digits,
                            input logic r, input logic t, input logic w);
    exp_q.push_back({digits, 13'd0, r, t, w});
    begin
      logic [31:0] e;
      e = exp_q.pop_front();
      chk({name, "_dut"}, {d3[i], d2[i], d1[i], d0[i], 13'd0, run_o[i], tick_o[i], wrap_o[i]}, e);
      chk({name, "_model"}, {time_bcd(m_time[i]), 13'd0, 1'(m_mode[i] == 1),
          1'((m_mode[i] == 1) && (m_phase[i] == div_of(i) - 1)), m_wrap[i]}, e);
    end
  endtask

  task automatic run_a();
    rst[0] = 1'b1; ss[0] = 1'b1; clr[0] = 1'b1;
    cyc(2);
    rst[0] = 1'b0; ss[0] = 1'b0; clr[0] = 1'b0;
    expect_lit(0, "reset", 16'h0000, 0, 0, 0);
    // start at edge 0, ten ticks by edge 100
    pulse_ss(0);
    expect_lit(0, "start", 16'h0000, 1, 0, 0);
    cyc(9);
    expect_lit(0, "first_tick", 16'h0000, 1, 1, 0);
    cyc(91);
    expect_lit(0, "t100", 16'h0010, 1, 0, 0);
    pulse_clr(0);
    expect_lit(0, "clear", 16'h0000, 0, 0, 0);
    // pause at prescaler 5, resume completes the partial tick in 5 cycles
    pulse_ss(0);
    cyc(14);
    pulse_ss(0);
    cyc(50);
    expect_lit(0, "paused", 16'h0001, 0, 0, 0);
    pulse_ss(0);
    cyc(4);
    expect_lit(0, "resume_tick", 16'h0001, 1, 1, 0);
    cyc(1);
    expect_lit(0, "resumed", 16'h0002, 1, 0, 0);
    // clear + start_stop on a tick cycle
    cyc(9);
    expect_lit(0, "pre_simul", 16'h0002, 1, 1, 0);
    clr[0] = 1'b1; ss[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0; ss[0] = 1'b0;
    expect_lit(0, "clr_ss_tick", 16'h0000, 0, 0, 0);
    // start_stop alone on a tick cycle commits the increment then pauses
    pulse_ss(0);
    cyc(9);
    pulse_ss(0);
    expect_lit(0, "ss_tick", 16'h0001, 0, 0, 0);
    // mid-run reset at 12.34
    pulse_clr(0);
    pulse_ss(0);
    cyc(12340);
    expect_lit(0, "t1234", 16'h1234, 1, 0, 0);
    cyc(3);
    pulse_rst(0);
    expect_lit(0, "midrun_reset", 16'h0000, 0, 0, 0);
    pulse_ss(0);
    cyc(9);
    expect_lit(0, "post_reset_tick", 16'h0000, 1, 1, 0);
    cyc(1);
    expect_lit(0, "post_reset_inc", 16'h0001, 1, 0, 0);
    cyc(5);
  endtask

  task automatic run_b();
    rst[1] = 1'b1; ss[1] = 1'b0; clr[1] = 1'b0;
    cyc(2);
    rst[1] = 1'b0;
    pulse_ss(1);
    cyc(19998);
    expect_lit(1, "full_scale", 16'h9999, 1, 0, 0);
    cyc(1);
    expect_lit(1, "wrap_tick", 16'h9999, 1, 1, 0);
    cyc(1);
    expect_lit(1, "wrapped", 16'h0000, 1, 0, 1);
    cyc(1);
    expect_lit(1, "wrap_once", 16'h0000, 1, 1, 0);
    cyc(1);
    expect_lit(1, "after_wrap", 16'h0001, 1, 0, 0);
    cyc(3);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_time[i] = 0; m_phase[i] = 0; m_mode[i] = 0; m_wrap[i] = 0; m_valid[i] = 0;
      rst[i] = 1'b1; ss[i] = 1'b0; clr[i] = 1'b0;
    end
    fork
      run_a();
      run_b();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
